// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder/comparator controller.
package nibble_serial_add_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the nibble index; a single-nibble build still needs one bit.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result bundle between the ALU front end and the nibble-serial controller.
interface nibble_serial_add_ctrl_if
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         gt;
    logic         ls;
    logic         eq;
    logic         error;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, gt, ls, eq, error
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, gt, ls, eq, error
    );

endinterface

// File: rtl/nibble_serial_add_ctrl_add4_cmp_slice.sv
// Combinational 4-bit add/compare slice: sum, carry, magnitude flags and signed overflow.
module add4_cmp_slice
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                gt4,
    output logic                ls4,
    output logic                ovf4
);
    logic [NIBBLE_W-1:0] low;
    logic [NIBBLE_W:0]   full;

    always_comb begin
        // low[3] is the carry into the top bit of the slice
        low  = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, ci};
        full = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        s    = full[NIBBLE_W-1:0];
        co   = full[NIBBLE_W];
        ovf4 = low[NIBBLE_W-1] ^ full[NIBBLE_W];
        gt4  = (x > y);
        ls4  = (x < y);
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Walks one shared add4_cmp_slice over wide operands, LSB nibble first, with chained carry.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_serial_add_ctrl_if.slave       bus
);
    localparam int unsigned W  = NIBBLE_W * NIBBLES;
    localparam int unsigned IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic          carry_q, cout_q, gt_q, ls_q, eq_q, err_q, busy_q, done_q;

    logic [NIBBLE_W-1:0] x, y, s;
    logic                co, gt4, ls4, ovf4;
    logic [W-1:0]        sum_nx;
    logic                gt_nx, ls_nx;

    always_comb begin
        x = '0;
        y = '0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx_q == IW'(i)) begin
                x = a_q[i*NIBBLE_W +: NIBBLE_W];
                y = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    add4_cmp_slice u_slice (
        .x    (x),
        .y    (y),
        .ci   (carry_q),
        .s    (s),
        .co   (co),
        .gt4  (gt4),
        .ls4  (ls4),
        .ovf4 (ovf4)
    );

    // Equal nibbles keep the verdict of the less-significant ones.
    always_comb begin
        sum_nx = sum_q;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx_q == IW'(i)) sum_nx[i*NIBBLE_W +: NIBBLE_W] = s;
        end
        gt_nx = gt_q;
        ls_nx = ls_q;
        if (x != y) begin
            gt_nx = gt4;
            ls_nx = ls4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            gt_q    <= 1'b0;
            ls_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        gt_q    <= 1'b0;
                        ls_q    <= 1'b0;
                        eq_q    <= 1'b0;
                        err_q   <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_nx;
                    carry_q <= co;
                    gt_q    <= gt_nx;
                    ls_q    <= ls_nx;
                    if (idx_q == LAST) begin
                        state_q <= ST_DONE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= co;
                        err_q   <= ovf4;
                        eq_q    <= ~gt_nx & ~ls_nx;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.gt    = gt_q;
    assign bus.ls    = ls_q;
    assign bus.eq    = eq_q;
    assign bus.error = err_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed plus random checks of nibble_serial_add_ctrl against a whole-word arithmetic model.
module tb_nibble_serial_add_ctrl;
    import nibble_serial_add_ctrl_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    nibble_serial_add_ctrl_if #(.NIBBLES(N)) bus ();

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain W-bit arithmetic on the whole operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] s, output logic co, output logic gt,
                         output logic ls, output logic eq, output logic er);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        s    = full[W-1:0];
        co   = full[W];
        gt   = (a > b);
        ls   = (a < b);
        eq   = (a == b);
        er   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin);
        logic [W-1:0] s;
        logic co, gt, ls, eq, er;
        model(a, b, cin, s, co, gt, ls, eq, er);
        check({tag, ".done"}, 64'(bus.done), 64'(1'b1));
        check({tag, ".busy"}, 64'(bus.busy), 64'(1'b0));
        check({tag, ".sum"}, 64'(bus.sum), 64'(s));
        check({tag, ".flags"}, 64'({bus.cout, bus.gt, bus.ls, bus.eq, bus.error}),
              64'({co, gt, ls, eq, er}));
    endtask

    // One full operation; optionally pulses start while busy, which must be ignored.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input bit poke_busy);
        bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        check({tag, ".busy0"}, 64'({bus.busy, bus.done}), 64'(2'b10));
        for (int k = 1; k < int'(N); k++) begin
            if (poke_busy && k == 1) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            check({tag, ".busyk"}, 64'({bus.busy, bus.done}), 64'(2'b10));
        end
        tick();
        check_result(tag, a, b, cin);
        tick();
        check({tag, ".after"}, 64'({bus.busy, bus.done}), 64'(2'b00));
    endtask

    initial begin
        logic [W-1:0] ra, rb, na, nb;
        logic rc, nc;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        #12;
        check("reset", 64'({bus.busy, bus.done, bus.sum, bus.cout, bus.gt, bus.ls, bus.eq,
                            bus.error}), 64'(0));
        rst_n = 1'b1;
        tick();

        do_op("t1", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        do_op("t2", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op("t3", 16'hA5A5, 16'hA5A5, 1'b1, 1'b0);
        do_op("t4", 16'h0001, 16'hFFFF, 1'b0, 1'b1);

        // Start held high: done every N+1 cycles, busy low only in done cycles.
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        bus.a = ra; bus.b = rb; bus.cin = rc; bus.start = 1'b1;
        tick();
        for (int op = 0; op < 4; op++) begin
            for (int k = 1; k < int'(N); k++) begin
                tick();
                check("b2b.busy", 64'({bus.busy, bus.done}), 64'(2'b10));
            end
            tick();
            check_result("b2b", ra, rb, rc);
            na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
            bus.a = na; bus.b = nb; bus.cin = nc;
            ra = na; rb = nb; rc = nc;
            tick();
            check("b2b.rerun", 64'({bus.busy, bus.done}), 64'(2'b10));
            // Skip the first RUN cycle, already checked above.
            if (op == 3) bus.start = 1'b0;
        end
        for (int k = 1; k < int'(N); k++) tick();
        tick();
        check_result("b2b.last", ra, rb, rc);
        tick();

        // Reset in the middle of RUN aborts without a done pulse.
        bus.a = 16'hFFFF; bus.b = 16'h1111; bus.cin = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort", 64'({bus.busy, bus.done, bus.sum, bus.cout, bus.gt, bus.ls, bus.eq,
                            bus.error}), 64'(0));
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < int'(N) + 2; k++) begin
            tick();
            check("abort.nodone", 64'({bus.busy, bus.done}), 64'(2'b00));
        end
        do_op("t6", 16'h0003, 16'h0004, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            ra = W'($urandom);
            rb = (r % 3 == 0) ? ra : W'($urandom);
            do_op("rand", ra, rb, 1'($urandom), bit'(r % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
